// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and constants for the unified-memory arbiter
package mem_arb_pkg;

  typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} state_t;
  typedef enum logic {OWN_I = 1'b0, OWN_D = 1'b1} owner_t;

  localparam logic [2:0] MEMOP_WORD  = 3'b010;
  localparam int         MEM_LAT_MAX = 4;
  localparam int         LAT_CW      = $clog2(MEM_LAT_MAX + 1);
  localparam int         STARVE_CW   = 4;

  // Load value for the ACCESS down-counter; the last ACCESS cycle sees 1.
  function automatic logic [LAT_CW-1:0] lat_load(input int lat);
    return LAT_CW'(lat);
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - fetch port, data port and memory port bundle of the arbiter
interface mem_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);

  logic          i_req;
  logic [AW-1:0] i_addr;
  logic          i_gnt;
  logic          i_rvalid;
  logic [DW-1:0] i_rdata;

  logic          d_req;
  logic          d_we;
  logic [2:0]    d_op;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_gnt;
  logic          d_rvalid;
  logic [DW-1:0] d_rdata;

  logic          m_en;
  logic          m_we;
  logic [2:0]    m_op;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic [DW-1:0] m_rdata;

  modport slave (
    input  i_req, i_addr,
    input  d_req, d_we, d_op, d_addr, d_wdata,
    input  m_rdata,
    output i_gnt, i_rvalid, i_rdata,
    output d_gnt, d_rvalid, d_rdata,
    output m_en, m_we, m_op, m_addr, m_wdata
  );

  modport master (
    output i_req, i_addr,
    output d_req, d_we, d_op, d_addr, d_wdata,
    output m_rdata,
    input  i_gnt, i_rvalid, i_rdata,
    input  d_gnt, d_rvalid, d_rdata,
    input  m_en, m_we, m_op, m_addr, m_wdata
  );

endinterface

// File: rtl/mem_arb_prio.sv
// rtl/mem_arb_prio.sv - data-first grant select with a fetch starvation guard
module mem_arb_prio
  import mem_arb_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic idle,
  input  logic i_req,
  input  logic d_req,
  output logic grant_i,
  output logic grant_d
);

  localparam logic [STARVE_CW-1:0] SMAX = STARVE_CW'(STARVE_MAX);

  logic [STARVE_CW-1:0] starve_cnt;
  logic                 starved;

  assign starved = i_req && (starve_cnt == SMAX);

  always_comb begin
    grant_i = 1'b0;
    grant_d = 1'b0;
    if (idle) begin
      if (d_req && !starved) begin
        grant_d = 1'b1;
      end else if (i_req) begin
        grant_i = 1'b1;
      end
    end
  end

  // Counts data grants that bypassed a waiting fetch; frozen while a transaction is in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_cnt <= '0;
    end else if (idle) begin
      if (grant_i || !i_req) begin
        starve_cnt <= '0;
      end else if (grant_d && (starve_cnt != SMAX)) begin
        starve_cnt <= starve_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - single-ported unified memory shared by fetch and data ports
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic         clk,
  input  logic         rst,
  mem_arbiter_if.slave bus
);

  state_t            state_q;
  state_t            state_d;
  logic [LAT_CW-1:0] lat_q;
  logic [LAT_CW-1:0] lat_d;
  logic              ready_q;
  logic              idle;
  logic              grant_i;
  logic              grant_d;
  logic              done;

  owner_t            owner_q;
  logic              m_en_q;
  logic              m_we_q;
  logic [2:0]        m_op_q;
  logic [AW-1:0]     m_addr_q;
  logic [DW-1:0]     m_wdata_q;
  logic              i_rvalid_q;
  logic [DW-1:0]     i_rdata_q;
  logic              d_rvalid_q;
  logic [DW-1:0]     d_rdata_q;

  // Grants are held off until the first clock after reset release.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ready_q <= 1'b0;
    end else begin
      ready_q <= 1'b1;
    end
  end

  assign idle = (state_q == IDLE) && ready_q;

  mem_arb_prio #(
    .STARVE_MAX(STARVE_MAX)
  ) u_prio (
    .clk    (clk),
    .rst    (rst),
    .idle   (idle),
    .i_req  (bus.i_req),
    .d_req  (bus.d_req),
    .grant_i(grant_i),
    .grant_d(grant_d)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      lat_q   <= '0;
    end else begin
      state_q <= state_d;
      lat_q   <= lat_d;
    end
  end

  always_comb begin
    state_d = state_q;
    lat_d   = lat_q;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        if (grant_i || grant_d) begin
          state_d = ACCESS;
          lat_d   = lat_load(MEM_LAT);
        end
      end
      ACCESS: begin
        if (lat_q == LAT_CW'(1)) begin
          state_d = IDLE;
          lat_d   = '0;
          done    = 1'b1;
        end else begin
          lat_d = lat_q - 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        lat_d   = '0;
      end
    endcase
  end

  // Request fields are captured at grant and stay on the memory port through ACCESS.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      owner_q    <= OWN_I;
      m_en_q     <= 1'b0;
      m_we_q     <= 1'b0;
      m_op_q     <= '0;
      m_addr_q   <= '0;
      m_wdata_q  <= '0;
      i_rvalid_q <= 1'b0;
      i_rdata_q  <= '0;
      d_rvalid_q <= 1'b0;
      d_rdata_q  <= '0;
    end else begin
      m_en_q     <= grant_i || grant_d;
      i_rvalid_q <= done && (owner_q == OWN_I);
      d_rvalid_q <= done && (owner_q == OWN_D);
      if (grant_d) begin
        owner_q   <= OWN_D;
        m_we_q    <= bus.d_we;
        m_op_q    <= bus.d_op;
        m_addr_q  <= bus.d_addr;
        m_wdata_q <= bus.d_wdata;
      end else if (grant_i) begin
        owner_q   <= OWN_I;
        m_we_q    <= 1'b0;
        m_op_q    <= MEMOP_WORD;
        m_addr_q  <= bus.i_addr;
        m_wdata_q <= '0;
      end
      if (done) begin
        if (owner_q == OWN_I) begin
          i_rdata_q <= bus.m_rdata;
        end else begin
          d_rdata_q <= m_we_q ? '0 : bus.m_rdata;
        end
      end
    end
  end

  assign bus.i_gnt    = grant_i;
  assign bus.d_gnt    = grant_d;
  assign bus.i_rvalid = i_rvalid_q;
  assign bus.i_rdata  = i_rdata_q;
  assign bus.d_rvalid = d_rvalid_q;
  assign bus.d_rdata  = d_rdata_q;
  assign bus.m_en     = m_en_q;
  assign bus.m_we     = m_we_q;
  assign bus.m_op     = m_op_q;
  assign bus.m_addr   = m_addr_q;
  assign bus.m_wdata  = m_wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter (MEM_LAT 1 and 3)
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  mem_arbiter_if #(.AW(32), .DW(32)) ba ();
  mem_arbiter_if #(.AW(32), .DW(32)) bb ();

  mem_arbiter #(.AW(32), .DW(32), .MEM_LAT(1), .STARVE_MAX(4)) dut_a (
    .clk(clk), .rst(rst), .bus(ba)
  );
  mem_arbiter #(.AW(32), .DW(32), .MEM_LAT(3), .STARVE_MAX(4)) dut_b (
    .clk(clk), .rst(rst), .bus(bb)
  );

  function automatic logic [31:0] memf(input logic [31:0] a);
    if (a == 32'h0000_0100) return 32'hDEAD_BEEF;
    return a ^ 32'h5A5A_0000;
  endfunction

  // Memory models: data is valid only in the cycle the arbiter should sample it.
  int age_a;
  int age_b;
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      age_a <= 0;
      age_b <= 0;
    end else begin
      if (ba.m_en) age_a <= 1;
      else if (age_a != 0 && age_a < 64) age_a <= age_a + 1;
      if (bb.m_en) age_b <= 1;
      else if (age_b != 0 && age_b < 64) age_b <= age_b + 1;
    end
  end

  always_comb begin
    ba.m_rdata = 32'hBAD0_BAD0;
    bb.m_rdata = 32'hBAD0_BAD0;
    if (ba.m_en) ba.m_rdata = memf(ba.m_addr);
    if (!bb.m_en && age_b == 2) bb.m_rdata = memf(bb.m_addr);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    ba.i_req = 1'b1; ba.d_req = 1'b1; ba.i_addr = 32'h200; ba.d_addr = 32'h40;
    ba.d_we = 1'b0; ba.d_op = 3'b010; ba.d_wdata = 32'h1234;
    bb.i_req = 1'b1; bb.d_req = 1'b1;
    repeat (3) tick();
    #1;
    checks++;
    if (ba.i_gnt !== 1'b0 || ba.d_gnt !== 1'b0 || bb.i_gnt !== 1'b0 || bb.d_gnt !== 1'b0) begin
      errors++;
      $display("FAIL reset_gnt got a=%b%b b=%b%b want 00 00", ba.i_gnt, ba.d_gnt, bb.i_gnt, bb.d_gnt);
    end
    checks++;
    if ({ba.m_en, ba.m_we, ba.m_op, ba.i_rvalid, ba.d_rvalid} !== 7'b0) begin
      errors++;
      $display("FAIL reset_ctrl got %b want 0", {ba.m_en, ba.m_we, ba.m_op, ba.i_rvalid, ba.d_rvalid});
    end
    checks++;
    if ({ba.m_addr, ba.m_wdata, ba.i_rdata, ba.d_rdata} !== 128'b0) begin
      errors++;
      $display("FAIL reset_data got %h want 0", {ba.m_addr, ba.m_wdata, ba.i_rdata, ba.d_rdata});
    end
    bb.i_req = 1'b0; bb.d_req = 1'b0;
    rst = 1'b1;
    #1;
    checks++;
    if (ba.d_gnt !== 1'b0) begin
      errors++;
      $display("FAIL release_early_gnt got %b want 0", ba.d_gnt);
    end
    tick();
    #1;
    checks++;
    if (ba.d_gnt !== 1'b1 || ba.i_gnt !== 1'b0) begin
      errors++;
      $display("FAIL release_gnt got i=%b d=%b want 0 1", ba.i_gnt, ba.d_gnt);
    end
    tick();
    ba.i_req = 1'b0; ba.d_req = 1'b0;
    repeat (4) tick();
  endtask

  task automatic test_fetch();
    ba.i_req = 1'b1; ba.i_addr = 32'h100;
    #1;
    checks++;
    if (ba.i_gnt !== 1'b1 || ba.d_gnt !== 1'b0 || ba.m_en !== 1'b0) begin
      errors++;
      $display("FAIL fetch_c0 got i_gnt=%b d_gnt=%b m_en=%b want 1 0 0", ba.i_gnt, ba.d_gnt, ba.m_en);
    end
    tick();
    ba.i_req = 1'b0;
    #1;
    checks++;
    if (ba.m_en !== 1'b1 || ba.m_we !== 1'b0 || ba.m_op !== 3'b010 || ba.i_rvalid !== 1'b0) begin
      errors++;
      $display("FAIL fetch_c1_ctrl got en=%b we=%b op=%b rv=%b want 1 0 010 0", ba.m_en, ba.m_we, ba.m_op, ba.i_rvalid);
    end
    checks++;
    if (ba.m_addr !== 32'h100 || ba.m_wdata !== 32'h0) begin
      errors++;
      $display("FAIL fetch_c1_bus got addr=%h wdata=%h want 00000100 00000000", ba.m_addr, ba.m_wdata);
    end
    tick();
    #1;
    checks++;
    if (ba.i_rvalid !== 1'b1 || ba.d_rvalid !== 1'b0 || ba.m_en !== 1'b0) begin
      errors++;
      $display("FAIL fetch_c2 got i_rv=%b d_rv=%b m_en=%b want 1 0 0", ba.i_rvalid, ba.d_rvalid, ba.m_en);
    end
    checks++;
    if (ba.i_rdata !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL fetch_rdata got %h want deadbeef", ba.i_rdata);
    end
    tick();
    #1;
    checks++;
    if (ba.i_rvalid !== 1'b0 || ba.i_rdata !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL fetch_hold got rv=%b rdata=%h want 0 deadbeef", ba.i_rvalid, ba.i_rdata);
    end
    tick();
  endtask

  task automatic test_write();
    ba.d_req = 1'b1; ba.d_we = 1'b1; ba.d_op = 3'b000; ba.d_addr = 32'h23; ba.d_wdata = 32'hAB;
    #1;
    checks++;
    if (ba.d_gnt !== 1'b1 || ba.i_gnt !== 1'b0) begin
      errors++;
      $display("FAIL write_gnt got i=%b d=%b want 0 1", ba.i_gnt, ba.d_gnt);
    end
    tick();
    ba.d_req = 1'b0; ba.d_we = 1'b0;
    #1;
    checks++;
    if (ba.m_en !== 1'b1 || ba.m_we !== 1'b1 || ba.m_op !== 3'b000 || ba.m_addr !== 32'h23 || ba.m_wdata !== 32'hAB) begin
      errors++;
      $display("FAIL write_c1 got en=%b we=%b op=%b addr=%h wdata=%h want 1 1 000 00000023 000000ab",
               ba.m_en, ba.m_we, ba.m_op, ba.m_addr, ba.m_wdata);
    end
    tick();
    #1;
    checks++;
    if (ba.d_rvalid !== 1'b1 || ba.d_rdata !== 32'h0 || ba.m_en !== 1'b0 || ba.i_rvalid !== 1'b0) begin
      errors++;
      $display("FAIL write_c2 got d_rv=%b d_rdata=%h m_en=%b i_rv=%b want 1 0 0 0", ba.d_rvalid, ba.d_rdata, ba.m_en, ba.i_rvalid);
    end
    tick();
  endtask

  task automatic test_conflict();
    logic [9:0]  exp_seq = 10'b10000_10000;
    logic [31:0] rd_d = '0;
    logic [31:0] rd_i = '0;
    bit          got_d = 1'b0;
    bit          got_i = 1'b0;
    bit          both = 1'b0;
    int          n = 0;
    ba.d_we = 1'b0; ba.d_op = 3'b010; ba.d_addr = 32'h40; ba.i_addr = 32'h200;
    ba.i_req = 1'b1; ba.d_req = 1'b1;
    for (int c = 0; c < 60 && n < 10; c++) begin
      #1;
      if (ba.i_gnt && ba.d_gnt) both = 1'b1;
      if (ba.d_rvalid && !got_d) begin got_d = 1'b1; rd_d = ba.d_rdata; end
      if (ba.i_rvalid && !got_i) begin got_i = 1'b1; rd_i = ba.i_rdata; end
      if (ba.i_gnt || ba.d_gnt) begin
        checks++;
        if (ba.i_gnt !== exp_seq[n]) begin
          errors++;
          $display("FAIL conflict_grant%0d got i_gnt=%b want %b", n, ba.i_gnt, exp_seq[n]);
        end
        n++;
      end
      tick();
    end
    ba.i_req = 1'b0; ba.d_req = 1'b0;
    checks++;
    if (n != 10 || both) begin
      errors++;
      $display("FAIL conflict_count got grants=%0d both=%b want 10 0", n, both);
    end
    checks++;
    if (rd_d !== memf(32'h40) || rd_i !== memf(32'h200)) begin
      errors++;
      $display("FAIL conflict_rdata got d=%h i=%h want %h %h", rd_d, rd_i, memf(32'h40), memf(32'h200));
    end
    repeat (3) tick();
  endtask

  task automatic test_lat3();
    int          gc[3];
    int          ec[3];
    int          rc[3];
    logic [31:0] rdv[3];
    int          ng = 0;
    int          ne = 0;
    int          nr = 0;
    bit          granted;
    bb.d_we = 1'b0; bb.d_op = 3'b010; bb.d_addr = 32'h80; bb.d_req = 1'b1;
    for (int k = 0; k < 3; k++) begin gc[k] = -100; ec[k] = -100; rc[k] = -100; rdv[k] = '0; end
    for (int c = 0; c < 40 && nr < 3; c++) begin
      #1;
      granted = bb.d_gnt;
      if (bb.d_gnt) begin if (ng < 3) gc[ng] = c; ng++; end
      if (bb.m_en) begin if (ne < 3) ec[ne] = c; ne++; end
      if (bb.d_rvalid) begin if (nr < 3) begin rc[nr] = c; rdv[nr] = bb.d_rdata; end nr++; end
      tick();
      if (granted) begin
        if (ng >= 3) bb.d_req = 1'b0;
        else bb.d_addr = 32'h80 + 32'(4 * ng);
      end
    end
    bb.d_req = 1'b0;
    checks++;
    if (ng != 3 || ne != 3 || nr != 3) begin
      errors++;
      $display("FAIL lat3_counts got gnt=%0d m_en=%0d rvalid=%0d want 3 3 3", ng, ne, nr);
    end
    checks++;
    if (gc[1] - gc[0] != 4 || gc[2] - gc[1] != 4) begin
      errors++;
      $display("FAIL lat3_spacing got %0d %0d want 4 4", gc[1] - gc[0], gc[2] - gc[1]);
    end
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (ec[k] != gc[k] + 1 || rc[k] != gc[k] + 4) begin
        errors++;
        $display("FAIL lat3_timing%0d got m_en=+%0d rvalid=+%0d want +1 +4", k, ec[k] - gc[k], rc[k] - gc[k]);
      end
      checks++;
      if (rdv[k] !== memf(32'h80 + 32'(4 * k))) begin
        errors++;
        $display("FAIL lat3_rdata%0d got %h want %h", k, rdv[k], memf(32'h80 + 32'(4 * k)));
      end
    end
    repeat (3) tick();
  endtask

  task automatic test_reset_mid();
    int seen = 0;
    bb.d_we = 1'b0; bb.d_addr = 32'h90; bb.d_req = 1'b1;
    #1;
    checks++;
    if (bb.d_gnt !== 1'b1) begin
      errors++;
      $display("FAIL rmid_gnt got %b want 1", bb.d_gnt);
    end
    tick();
    bb.d_req = 1'b0;
    #1;
    checks++;
    if (bb.m_en !== 1'b1) begin
      errors++;
      $display("FAIL rmid_c1_en got %b want 1", bb.m_en);
    end
    tick();
    rst = 1'b0;
    #1;
    checks++;
    if (bb.m_en !== 1'b0 || bb.m_addr !== 32'h0 || bb.d_gnt !== 1'b0) begin
      errors++;
      $display("FAIL rmid_clear got en=%b addr=%h gnt=%b want 0 0 0", bb.m_en, bb.m_addr, bb.d_gnt);
    end
    tick();
    tick();
    rst = 1'b1;
    for (int c = 0; c < 8; c++) begin
      #1;
      if (bb.d_rvalid) seen++;
      tick();
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL rmid_rvalid got %0d pulses want 0", seen);
    end
    bb.d_addr = 32'h94; bb.d_req = 1'b1;
    #1;
    checks++;
    if (bb.d_gnt !== 1'b1) begin
      errors++;
      $display("FAIL rmid_idle_gnt got %b want 1", bb.d_gnt);
    end
    tick();
    bb.d_req = 1'b0;
    repeat (5) tick();
    ba.i_addr = 32'h300; ba.i_req = 1'b1;
    tick();
    ba.i_req = 1'b0;
    rst = 1'b0;
    #1;
    checks++;
    if (ba.m_en !== 1'b0) begin
      errors++;
      $display("FAIL rmid_c1_withdraw got %b want 0", ba.m_en);
    end
    tick();
    rst = 1'b1;
    repeat (3) tick();
  endtask

  initial begin
    ba.i_req = 1'b0; ba.i_addr = '0; ba.d_req = 1'b0; ba.d_we = 1'b0; ba.d_op = '0;
    ba.d_addr = '0; ba.d_wdata = '0;
    bb.i_req = 1'b0; bb.i_addr = '0; bb.d_req = 1'b0; bb.d_we = 1'b0; bb.d_op = '0;
    bb.d_addr = '0; bb.d_wdata = '0;
    test_reset();
    test_fetch();
    test_write();
    test_conflict();
    test_lat3();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired want finish before 200000");
    $fatal(1);
  end

endmodule
